// File: rtl/seq_feeder_pkg.sv
// rtl/seq_feeder_pkg.sv - shared widths and FSM state encoding for the sequence feeder
package seq_feeder_pkg;

   // Base encoding width shared by query and target streams
   localparam int BP_WIDTH   = 2;
   // Width of PE_end; a query holds 1..2^LOG_N bases
   localparam int LOG_N      = 4;
   // Width of the target length and issue counters
   localparam int TLEN_WIDTH = 16;

   // Job sequencing states, 3-bit encoding
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_NEWSEQ   = 3'd1,
      ST_LOAD_S   = 3'd2,
      ST_STREAM_T = 3'd3,
      ST_WAIT_TB  = 3'd4,
      ST_ACK      = 3'd5
   } state_e;

endpackage

// File: rtl/bp_skid_buffer.sv
// rtl/bp_skid_buffer.sv - two-entry base FIFO that absorbs one cycle of downstream stall slip
module bp_skid_buffer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   input  logic         pop_i,
   output logic [W-1:0] pop_data_o,
   output logic         full_o,
   output logic         empty_o
);

   logic [W-1:0] ent0_q;
   logic [W-1:0] ent1_q;
   logic [1:0]   cnt_q;
   logic         push_eff;
   logic         pop_eff;

   // Requests against a full/empty buffer are dropped here so callers cannot corrupt the count
   assign push_eff   = push_i & (cnt_q != 2'd2);
   assign pop_eff    = pop_i & (cnt_q != 2'd0);
   assign full_o     = (cnt_q == 2'd2);
   assign empty_o    = (cnt_q == 2'd0);
   assign pop_data_o = ent0_q;

   // Entry 0 is always the head; a pop shifts entry 1 forward
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         ent0_q <= '0;
         ent1_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         if (push_eff && !pop_eff) begin
            if (cnt_q == 2'd0) begin
               ent0_q <= push_data_i;
            end else begin
               ent1_q <= push_data_i;
            end
            cnt_q <= cnt_q + 2'd1;
         end else if (pop_eff && !push_eff) begin
            ent0_q <= ent1_q;
            cnt_q  <= cnt_q - 2'd1;
         end else if (pop_eff && push_eff) begin
            // Only reachable with exactly one entry held: replace the head in place
            ent0_q <= push_data_i;
         end
      end
   end

endmodule

// File: rtl/seq_feeder.sv
// rtl/seq_feeder.sv - host-to-DP job transmitter: new_seq, query load, target stream, traceback close
module seq_feeder
   import seq_feeder_pkg::*;
#(
   parameter int BP_W   = BP_WIDTH,
   parameter int LOGN   = LOG_N,
   parameter int TLEN_W = TLEN_WIDTH
) (
   input  logic              clk,
   input  logic              reset_i,
   input  logic              job_start,
   input  logic [LOGN-1:0]   job_s_len,
   input  logic [TLEN_W-1:0] job_t_len,
   input  logic [BP_W-1:0]   s_data,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [BP_W-1:0]   t_data,
   input  logic              t_valid,
   output logic              t_ready,
   output logic [BP_W-1:0]   S,
   output logic              s_update,
   output logic              new_seq,
   output logic [LOGN-1:0]   PE_end,
   output logic [BP_W-1:0]   T,
   output logic              valid,
   input  logic              busy,
   input  logic              done,
   output logic              ack,
   output logic              job_busy,
   output logic              job_err
);

   localparam logic [LOGN-1:0]   S_ONE = LOGN'(1);
   localparam logic [TLEN_W-1:0] T_ONE = TLEN_W'(1);

   state_e            state_q;
   state_e            state_d;
   logic [LOGN-1:0]   pe_end_q;
   logic [LOGN-1:0]   s_cnt_q;
   logic [TLEN_W-1:0] t_len_q;
   logic [TLEN_W-1:0] t_acc_q;
   logic [TLEN_W-1:0] t_iss_q;
   logic [BP_W-1:0]   s_q;
   logic [BP_W-1:0]   t_q;
   logic              s_upd_q;
   logic              valid_q;
   logic              err_q;
   logic [BP_W-1:0]   skid_head;
   logic              skid_full;
   logic              skid_empty;
   logic              start_ok;
   logic              s_hs;
   logic              t_hs;
   logic              pop;
   logic              s_last;
   logic              t_last;

   assign start_ok = job_start & (state_q == ST_IDLE) & (job_t_len != '0);
   assign s_hs     = s_valid & s_ready;
   assign t_hs     = t_valid & t_ready;
   // busy is the DP's registered view, so the base issued as it rises is still taken
   assign pop      = (state_q == ST_STREAM_T) & ~skid_empty & ~busy;
   assign s_last   = s_hs & (s_cnt_q == pe_end_q);
   assign t_last   = pop & (t_iss_q == (t_len_q - T_ONE));

   assign S        = s_q;
   assign s_update = s_upd_q;
   assign T        = t_q;
   assign valid    = valid_q;
   assign PE_end   = pe_end_q;
   assign job_err  = err_q;

   bp_skid_buffer #(
      .W (BP_W)
   ) u_skid (
      .clk         (clk),
      .rst_ni      (reset_i),
      .push_i      (t_hs),
      .push_data_i (t_data),
      .pop_i       (pop),
      .pop_data_o  (skid_head),
      .full_o      (skid_full),
      .empty_o     (skid_empty)
   );

   // State register
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and phase-qualified handshake/pulse outputs
   always_comb begin
      state_d  = state_q;
      new_seq  = 1'b0;
      s_ready  = 1'b0;
      t_ready  = 1'b0;
      ack      = 1'b0;
      job_busy = (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d = ST_NEWSEQ;
            end
         end
         ST_NEWSEQ: begin
            new_seq = 1'b1;
            state_d = ST_LOAD_S;
         end
         ST_LOAD_S: begin
            s_ready = 1'b1;
            if (s_last) begin
               state_d = ST_STREAM_T;
            end
         end
         ST_STREAM_T: begin
            // Never take more target bases from the host than the job length
            t_ready = ~skid_full & (t_acc_q != t_len_q);
            if (t_last) begin
               state_d = ST_WAIT_TB;
            end
         end
         ST_WAIT_TB: begin
            if (done) begin
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            ack     = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Job lengths, base counters and the registered S/T ports toward the DP
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         pe_end_q <= '0;
         s_cnt_q  <= '0;
         t_len_q  <= '0;
         t_acc_q  <= '0;
         t_iss_q  <= '0;
         s_q      <= '0;
         t_q      <= '0;
         s_upd_q  <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         if (start_ok) begin
            pe_end_q <= job_s_len;
            t_len_q  <= job_t_len;
            s_cnt_q  <= '0;
            t_acc_q  <= '0;
            t_iss_q  <= '0;
         end else if (state_q == ST_ACK) begin
            pe_end_q <= '0;
         end
         if (s_hs) begin
            s_cnt_q <= s_cnt_q + S_ONE;
         end
         if (t_hs) begin
            t_acc_q <= t_acc_q + T_ONE;
         end
         if (pop) begin
            t_iss_q <= t_iss_q + T_ONE;
         end
         s_upd_q <= s_hs;
         s_q     <= s_hs ? s_data : '0;
         valid_q <= pop;
         t_q     <= pop ? skid_head : '0;
      end
   end

   // Sticky error: bad length or overlapping start; any accepted start clears it
   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         err_q <= 1'b0;
      end else if (job_start) begin
         if (state_q != ST_IDLE) begin
            err_q <= 1'b1;
         end else begin
            err_q <= (job_t_len == '0);
         end
      end
   end

endmodule
